data_mem_ctrl: RTL and testbench

Load/store initiator sitting between the MEM pipeline stage and the 128-word data memory (7-bit word address, combinational read while read-enable is high, write committed at posedge while write-enable is high). It accepts byte-addressed requests over a valid/ready handshake and performs word, halfword and byte loads with sign or zero extension. Word stores are issued directly. Sub-word stores are done as read-modify-write. One response pulse is returned per request, and misaligned or out-of-range requests are flagged as errors.

---
 rtl/data_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Load/store initiator between the MEM stage and a single-port word-addressed data memory.
// Latency accept->response: error 1, load 2, word store 2, sub-word store (read-modify-write) 3.
// Backpressure: req_ready_o only in IDLE; responses cannot be stalled by the consumer.
module data_mem_ctrl #(
    parameter int          ADDR_W    = 7,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] waddr;
        logic [1:0]        lane;
        logic [1:0]        size;
        logic              uns;
        logic              err;
        logic [31:0]       wdata;
    } req_t;

    state_t      state;
    req_t        req_q;
    logic [31:0] result_q;
    logic [31:0] off;
    logic        dec_err;

    assign off = req_addr_i - BASE_ADDR;

    // Anything at or beyond the byte size of the memory is out of range.
    always_comb begin
        dec_err = (req_size_i == 2'b11)
                | ((req_size_i == 2'b01) & off[0])
                | ((req_size_i == 2'b10) & (|off[1:0]))
                | (|off[31:ADDR_W+2]);
    end

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {lane, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] mask;
        mask = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {lane, 3'b000};
        return (w & ~mask) | ((d << {lane, 3'b000}) & mask);
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            req_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q.waddr <= off[ADDR_W+1:2];
                        req_q.lane  <= off[1:0];
                        req_q.size  <= req_size_i;
                        req_q.uns   <= req_unsigned_i;
                        req_q.err   <= dec_err;
                        req_q.wdata <= req_wdata_i;
                        result_q    <= '0;
                        if (dec_err)                 state <= RESP;
                        else if (!req_write_i)       state <= LOAD;
                        else if (req_size_i == 2'b10) state <= STORE;
                        else                         state <= RMW_RD;
                    end
                end
                LOAD: begin
                    result_q <= load_ext(mem_rdata_i, req_q.lane, req_q.size, req_q.uns);
                    state    <= RESP;
                end
                RMW_RD: begin
                    req_q.wdata <= merge(mem_rdata_i, req_q.wdata, req_q.lane, req_q.size);
                    state       <= STORE;
                end
                STORE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes are pure state decodes so a reset drops them immediately.
    assign req_ready_o = (state == IDLE);
    assign mem_read_o  = (state == LOAD) || (state == RMW_RD);
    assign mem_write_o = (state == STORE);
    assign mem_addr_o  = (mem_read_o || mem_write_o) ? req_q.waddr : '0;
    assign mem_wdata_o = mem_write_o ? req_q.wdata : '0;
    assign rsp_valid_o = (state == RESP);
    assign rsp_err_o   = rsp_valid_o & req_q.err;
    assign rsp_rdata_o = rsp_valid_o ? result_q : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array reference memory, directed scenarios and randomized traffic.
module tb_data_mem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_write_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [6:0]  mem_addr_o;
    logic        mem_read_o, mem_write_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;

    always #5 clk_i = ~clk_i;

    data_mem_ctrl #(.ADDR_W(7), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Device-side memory.
    logic [31:0] tb_mem [0:127];
    assign mem_rdata_i = mem_read_o ? tb_mem[mem_addr_o] : 32'h0;
    always @(posedge clk_i) if (mem_write_o) tb_mem[mem_addr_o] <= mem_wdata_o;

    // Reference model: memory as a flat little-endian byte array.
    logic [7:0] ref_b [0:511];

    int errors = 0;
    int checks = 0;

    int          obs_lat, obs_rd, obs_wr;
    logic        obs_err, obs_both, obs_timeout, obs_after;
    logic [31:0] obs_rdata, obs_wdata;
    logic [6:0]  obs_waddr;

    function automatic logic pred_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 512);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int i;
        logic [31:0] v;
        i = int'(a[8:0]);
        if (sz == 2'd0) begin
            v = ref_b[i];
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = ref_b[i] + 256 * ref_b[i+1];
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = ref_b[i] + 256 * ref_b[i+1] + 65536 * ref_b[i+2] + 16777216 * ref_b[i+3];
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_b[int'(a[8:0]) + k] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    function automatic int exp_lat(input logic wr, input logic [1:0] sz, input logic er);
        if (er) return 1;
        if (!wr || sz == 2'd2) return 2;
        return 3;
    endfunction

    // Issue one request, then keep valid high with junk while busy to exercise "ignored outside IDLE".
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int tries, cyc;
        obs_lat = 0; obs_rd = 0; obs_wr = 0; obs_err = 1'b0; obs_both = 1'b0;
        obs_timeout = 1'b0; obs_after = 1'b0; obs_rdata = '0; obs_wdata = '0; obs_waddr = '0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = wr; req_size_i = sz; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wd;
        tries = 0;
        while (!req_ready_o && tries < 20) begin @(negedge clk_i); tries++; end
        if (!req_ready_o) begin obs_timeout = 1'b1; req_valid_i = 1'b0; return; end
        @(posedge clk_i); #1;
        req_write_i = 1'($urandom); req_size_i = 2'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;
        cyc = 1;
        while (cyc <= 10) begin
            if (mem_read_o) obs_rd++;
            if (mem_write_o) begin obs_wr++; obs_waddr = mem_addr_o; obs_wdata = mem_wdata_o; end
            if (mem_read_o && mem_write_o) obs_both = 1'b1;
            if (rsp_valid_o) begin obs_lat = cyc; obs_err = rsp_err_o; obs_rdata = rsp_rdata_o; break; end
            @(posedge clk_i); #1;
            cyc++;
        end
        if (obs_lat == 0) obs_timeout = 1'b1;
        @(posedge clk_i); #1;
        obs_after = rsp_valid_o;
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'd2; req_unsigned_i = 1'b0;
        req_addr_i = 32'h10; req_wdata_i = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++; if ({rsp_valid_o, rsp_err_o, mem_read_o, mem_write_o} !== 4'b0) begin errors++;
                $display("FAIL reset_strobes cyc%0d got=%b want=0000", c, {rsp_valid_o, rsp_err_o, mem_read_o, mem_write_o}); end
            checks++; if ({rsp_rdata_o, mem_wdata_o, mem_addr_o} !== 71'b0) begin errors++;
                $display("FAIL reset_buses cyc%0d rdata=%h wdata=%h addr=%h want 0", c, rsp_rdata_o, mem_wdata_o, mem_addr_o); end
        end
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end
        checks++; if (mem_write_o !== 1'b0 || rsp_valid_o !== 1'b0) begin errors++;
            $display("FAIL reset_no_accept wr=%b rsp=%b want 0 0", mem_write_o, rsp_valid_o); end
    endtask

    task automatic test_word_store_load();
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        ref_store(32'h10, 2'd2, 32'hDEAD_BEEF);
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL wst_latency got=%0d want=2", obs_lat); end
        checks++; if (obs_wr !== 1 || obs_rd !== 0) begin errors++; $display("FAIL wst_strobes wr=%0d rd=%0d want 1 0", obs_wr, obs_rd); end
        checks++; if (obs_waddr !== 7'd4) begin errors++; $display("FAIL wst_addr got=%0d want=4", obs_waddr); end
        checks++; if (obs_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wst_data got=%h want=deadbeef", obs_wdata); end
        checks++; if (obs_rdata !== 32'h0 || obs_err !== 1'b0) begin errors++; $display("FAIL wst_rsp rdata=%h err=%b want 0 0", obs_rdata, obs_err); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++; if (obs_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wld_data got=%h want=deadbeef", obs_rdata); end
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL wld_latency got=%0d want=2", obs_lat); end
        checks++; if (obs_after !== 1'b0) begin errors++; $display("FAIL wld_pulse rsp_valid still high after one cycle"); end
    endtask

    task automatic test_subword_loads();
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        checks++; if (obs_rdata !== 32'hFFFF_FFDE) begin errors++; $display("FAIL lb_signed got=%h want=ffffffde", obs_rdata); end
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        checks++; if (obs_rdata !== 32'h0000_00DE) begin errors++; $display("FAIL lb_unsigned got=%h want=000000de", obs_rdata); end
        do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        checks++; if (obs_rdata !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_signed got=%h want=ffffbeef", obs_rdata); end
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        checks++; if (obs_rdata !== 32'h0000_DEAD) begin errors++; $display("FAIL lh_upper got=%h want=0000dead", obs_rdata); end
    endtask

    task automatic test_rmw();
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hABCD_EF55);
        ref_store(32'h11, 2'd0, 32'hABCD_EF55);
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL rmw_latency got=%0d want=3", obs_lat); end
        checks++; if (obs_rd !== 1 || obs_wr !== 1) begin errors++; $display("FAIL rmw_strobes rd=%0d wr=%0d want 1 1", obs_rd, obs_wr); end
        checks++; if (obs_wdata !== 32'hDEAD_55EF) begin errors++; $display("FAIL rmw_wdata got=%h want=dead55ef", obs_wdata); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++; if (obs_rdata !== 32'hDEAD_55EF) begin errors++; $display("FAIL rmw_reload got=%h want=dead55ef", obs_rdata); end
    endtask

    task automatic test_errors();
        logic [1:0]  e_sz [4];
        logic [31:0] e_ad [4];
        e_sz[0] = 2'd1; e_ad[0] = 32'h11;
        e_sz[1] = 2'd2; e_ad[1] = 32'h202;
        e_sz[2] = 2'd2; e_ad[2] = 32'h200;
        e_sz[3] = 2'd3; e_ad[3] = 32'h10;
        for (int i = 0; i < 4; i++) begin
            do_req(1'(i % 2), e_sz[i], 1'b0, e_ad[i], 32'hFFFF_FFFF);
            checks++; if (obs_err !== 1'b1 || obs_lat !== 1) begin errors++;
                $display("FAIL err_case%0d err=%b lat=%0d want 1 1", i, obs_err, obs_lat); end
            checks++; if (obs_rd !== 0 || obs_wr !== 0 || obs_rdata !== 32'h0) begin errors++;
                $display("FAIL err_case%0d_side rd=%0d wr=%0d rdata=%h want 0 0 0", i, obs_rd, obs_wr, obs_rdata); end
        end
    endtask

    task automatic test_midop_reset();
        int rsp_seen, wr_seen;
        rsp_seen = 0; wr_seen = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
        req_addr_i = 32'h14; req_wdata_i = 32'h0000_00A5;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        checks++; if (mem_read_o !== 1'b1) begin errors++; $display("FAIL midrst_in_rmw mem_read=%b want=1", mem_read_o); end
        #1 rst_i = 1'b0;
        #1;
        checks++; if (mem_read_o !== 1'b0 || mem_addr_o !== 7'd0) begin errors++;
            $display("FAIL midrst_async read=%b addr=%0d want 0 0", mem_read_o, mem_addr_o); end
        repeat (2) begin
            @(posedge clk_i); #1;
            if (mem_write_o) wr_seen++;
            if (rsp_valid_o) rsp_seen++;
        end
        @(negedge clk_i); rst_i = 1'b1;
        repeat (4) begin
            @(posedge clk_i); #1;
            if (mem_write_o) wr_seen++;
            if (rsp_valid_o) rsp_seen++;
        end
        checks++; if (wr_seen !== 0 || rsp_seen !== 0) begin errors++;
            $display("FAIL midrst_quiet writes=%0d rsps=%0d want 0 0", wr_seen, rsp_seen); end
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        checks++; if (obs_rdata !== ref_load(32'h14, 2'd2, 1'b0)) begin errors++;
            $display("FAIL midrst_reload got=%h want=%h", obs_rdata, ref_load(32'h14, 2'd2, 1'b0)); end
    endtask

    task automatic test_back_to_back();
        logic        wr, uns, er;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp_r, exp_w;
        int          el;
        for (int n = 0; n < 80; n++) begin
            wr  = 1'($urandom);
            uns = 1'($urandom);
            sz  = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            wd  = $urandom;
            if ($urandom % 10 == 0) a = ($urandom % 2 == 0) ? $urandom_range(512, 1023) : $urandom;
            else a = $urandom_range(0, 511);
            if ($urandom % 4 != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            er    = pred_err(a, sz);
            el    = exp_lat(wr, sz, er);
            exp_r = (er || wr) ? 32'h0 : ref_load(a, sz, uns);
            if (wr && !er) ref_store(a, sz, wd);
            exp_w = er ? 32'h0 : ref_load(a & ~32'd3, 2'd2, 1'b0);
            do_req(wr, sz, uns, a, wd);
            checks++; if (obs_timeout) begin errors++; $display("FAIL rnd%0d_timeout no response", n); end
            checks++; if (obs_lat !== el || obs_err !== er) begin errors++;
                $display("FAIL rnd%0d_lat_err lat=%0d err=%b want %0d %b", n, obs_lat, obs_err, el, er); end
            checks++; if (obs_rdata !== exp_r) begin errors++;
                $display("FAIL rnd%0d_rdata a=%h sz=%0d got=%h want=%h", n, a, sz, obs_rdata, exp_r); end
            checks++; if (obs_both || obs_after) begin errors++;
                $display("FAIL rnd%0d_protocol both_strobes=%b long_rsp=%b want 0 0", n, obs_both, obs_after); end
            checks++; if (obs_wr !== ((wr && !er) ? 1 : 0) || obs_rd !== ((!er && (!wr || sz != 2'd2)) ? 1 : 0)) begin errors++;
                $display("FAIL rnd%0d_strobes rd=%0d wr=%0d", n, obs_rd, obs_wr); end
            if (wr && !er) begin
                checks++; if (obs_waddr !== a[8:2] || obs_wdata !== exp_w) begin errors++;
                    $display("FAIL rnd%0d_write addr=%0d data=%h want %0d %h", n, obs_waddr, obs_wdata, a[8:2], exp_w); end
            end
        end
        for (int w = 0; w < 128; w++) begin
            checks++; if (tb_mem[w] !== ref_load(32'(w * 4), 2'd2, 1'b0)) begin errors++;
                $display("FAIL sweep_word%0d got=%h want=%h", w, tb_mem[w], ref_load(32'(w * 4), 2'd2, 1'b0)); end
        end
    endtask

    initial begin
        for (int w = 0; w < 128; w++) begin
            tb_mem[w] = $urandom;
            for (int k = 0; k < 4; k++) ref_b[w * 4 + k] = 8'(tb_mem[w] >> (8 * k));
        end
        test_reset();
        test_word_store_load();
        test_subword_loads();
        test_rmw();
        test_errors();
        test_midop_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
